pwm_slew_limiter: RTL and testbench
===================================

# pwm_slew_limiter

Command-conditioning stage placed directly upstream of each motor PWM generator. It accepts raw 8-bit pulse-width commands from the peripheral register file and produces a slew-rate-limited `width` that changes only at 20 ms frame boundaries. A frame watchdog forces the output back to neutral (127, 1.5 ms) when commands stop arriving. One instance drives each of the left and right generators from the shared 255 kHz PWM clock.

## Interface
- `FRAME_CYCLES`, default 5100: clk_255kHz cycles per 20 ms frame. Matches the generator period.
- `STEP_MAX`, default 8: maximum change in `width` per frame, in counts. Range 1..255.
- `NEUTRAL`, default 127: reset and failsafe width.
- `TIMEOUT_FRAMES`, default 25: frames without a command before failsafe (500 ms).

- `clk_255kHz`  in  1: PWM-domain clock.
- `reset`  in  1: synchronous, active-high.
- `target`  in  8: commanded width. 0 = 1 ms, 255 = 2 ms.
- `target_valid`  in  1: single-cycle strobe; `target` is sampled when high.
- `width`  out  8: limited width. Feeds the PWM generator `width` input.
- `frame_tick`  out  1: high for one cycle at the end of each frame.
- `failsafe`  out  1: high while in the FAILSAFE state.
- `at_target`  out  1: high when `width` equals the effective target.

## Operation
- **Frame counter**
  - Range 0..FRAME_CYCLES-1; wraps to 0.
  - `frame_tick` = (counter == FRAME_CYCLES-1), decoded from the registered counter.
- **Target register**
  - Loads `target` on any cycle with `target_valid` = 1.
  - Back-to-back strobes are allowed; the last one before a tick wins.
- **Watchdog**
  - Frame count saturates at TIMEOUT_FRAMES.
  - Cleared on any `target_valid` cycle.
  - Otherwise incremented on each `frame_tick`.
  - If `target_valid` and `frame_tick` occur in the same cycle, the clear wins.
- **State machine**
  - RUN → FAILSAFE when the watchdog reaches TIMEOUT_FRAMES.
  - FAILSAFE → RUN on the first `target_valid`; `failsafe` deasserts in the next cycle.
  - `failsafe` = (state == FAILSAFE), registered.
- **Effective target**: NEUTRAL in FAILSAFE; the target register in RUN.
- **Slew update**, on each `frame_tick`:
  - diff = effective target − width, computed as 9-bit signed.
  - width += sign(diff) × min(|diff|, STEP_MAX).
  - The result never leaves 0..255, so no wrap is possible.
  - `width` holds between ticks.
- **Tick-cycle sampling**: a `target_valid` in the tick cycle is not used by that tick's update. The update uses the target register value held before the edge; the new target takes effect at the next tick.
- **at_target**: combinational compare of `width` against the effective target.

## Timing
- **Reset values (one cycle after `reset` is sampled high)**:
  - Frame counter 0, watchdog 0, state RUN.
  - Target register NEUTRAL, `width` NEUTRAL.
  - `frame_tick` 0, `failsafe` 0, `at_target` 1.
- **Reset mid-ramp**: `width` snaps to NEUTRAL with no slewing, and the frame phase restarts.
- **First tick**: `frame_tick` first asserts FRAME_CYCLES cycles after reset deasserts, i.e. when the counter reaches FRAME_CYCLES-1.
- **Width latency**: the new `width` is visible in the cycle after `frame_tick`. Worst-case latency from command to first width change is FRAME_CYCLES+1 cycles.
- **Full swing**: from a 0 to 255 difference, reaching the target takes ceil(255/STEP_MAX) frames = 32 frames at defaults.
- **Failsafe entry**: `failsafe` rises in the cycle after the TIMEOUT_FRAMES-th consecutive tick with no command. `width` starts ramping to NEUTRAL at the following tick.
- **Stable reached target**: `width` does not change at a tick when diff = 0.

## Configuration
- **`PWM_SLEW_BYPASS_EN`**
  - Defined: the step limit is removed, and each tick sets `width` to the effective target.
  - Frame alignment, watchdog and failsafe behave identically in both builds.
  - Undefined (default): slew limiting by STEP_MAX as specified above.

## Test plan
- **Reset**: assert `reset` mid-frame with `width` = 200 → next cycle `width` = 127, `failsafe` = 0, `at_target` = 1; first `frame_tick` exactly 5100 cycles after reset deasserts.
- **Ramp up**: `target` = 255 strobed → `width` takes 135, 143, … at successive ticks; reaches 255 after tick 16; `at_target` = 1 from then on; no overshoot.
- **Ramp down**: `target` = 0 from 127 → tick 15 gives 7, tick 16 gives 0 (final step 7), then `width` holds at 0.
- **Watchdog**: one strobe with `target` = 255, then silence.
  - `failsafe` rises one cycle after tick 25.
  - `width` ramps down to 127 in steps of 8.
  - A new strobe with `target` = 50 clears `failsafe` next cycle, and the ramp proceeds toward 50.
- **Collision**: `target_valid` with `target` = 200 in the `frame_tick` cycle, with the previous target 127 and `width` 127 → no width change at that tick, watchdog 0; `width` = 135 after the next tick.
- **Bypass build** (`PWM_SLEW_BYPASS_EN` defined): `target` = 255 from 127 → `width` = 255 in the cycle after the next tick.

Source files
------------

// File: rtl/pwm_slew_limiter.sv
// pwm_slew_limiter: frame-aligned slew-rate limiter with command watchdog
// for one motor PWM generator, clocked from the shared 255 kHz PWM clock.
//
// Ports:
//   clk_255kHz    in   PWM-domain clock
//   reset         in   synchronous, active-high
//   target[7:0]   in   commanded width (0 = 1 ms, 255 = 2 ms)
//   target_valid  in   single-cycle strobe, target sampled when high
//   width[7:0]    out  limited width, changes only after a frame tick
//   frame_tick    out  high in the last cycle of each frame
//   failsafe      out  high while commands have timed out
//   at_target     out  width equals the effective target
//
// Build option: define PWM_SLEW_BYPASS_EN to drop the step limit so each
// tick jumps width straight to the effective target.

module pwm_slew_limiter #(
    parameter int FRAME_CYCLES   = 5100,
    parameter int STEP_MAX       = 8,
    parameter int NEUTRAL        = 127,
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic       clk_255kHz,
    input  logic       reset,
    input  logic [7:0] target,
    input  logic       target_valid,
    output logic [7:0] width,
    output logic       frame_tick,
    output logic       failsafe,
    output logic       at_target
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [CW-1:0] LAST   = CW'(FRAME_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_FRAMES);
    localparam logic [7:0]    NEUT   = 8'(NEUTRAL);

    typedef enum logic {
        RUN      = 1'b0,
        FAILSAFE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] frame_cnt;
    logic [WW-1:0] wd_cnt;
    logic [WW-1:0] wd_next;
    logic [7:0]    target_q;
    logic [7:0]    eff_target;
    logic [7:0]    width_next;

    assign frame_tick = (frame_cnt == LAST);
    assign failsafe   = (state == FAILSAFE);
    assign eff_target = failsafe ? NEUT : target_q;
    assign at_target  = (width == eff_target);

    // A command strobe always clears the watchdog, even on a tick cycle.
    always_comb begin
        wd_next = wd_cnt;
        if (target_valid) begin
            wd_next = '0;
        end else if (frame_tick && (wd_cnt != WD_MAX)) begin
            wd_next = wd_cnt + 1'b1;
        end
    end

    // Entry looks at the next watchdog value so failsafe rises in the
    // cycle right after the timing-out tick.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (wd_next == WD_MAX) begin
                    state_next = FAILSAFE;
                end
            end
            FAILSAFE: begin
                if (target_valid) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

`ifdef PWM_SLEW_BYPASS_EN
    assign width_next = eff_target;
`else
    logic [8:0] diff;
    logic [8:0] mag;
    logic [7:0] step;

    // 9-bit difference; bit 8 is the sign. The clamped step never exceeds
    // the distance to the target, so width stays within 0..255.
    always_comb begin
        diff = {1'b0, eff_target} - {1'b0, width};
        mag  = diff[8] ? (9'd0 - diff) : diff;
        step = (mag > 9'(STEP_MAX)) ? 8'(STEP_MAX) : mag[7:0];
        width_next = diff[8] ? (width - step) : (width + step);
    end
`endif

    always_ff @(posedge clk_255kHz) begin
        if (reset) begin
            frame_cnt <= '0;
            wd_cnt    <= '0;
            state     <= RUN;
            target_q  <= NEUT;
            width     <= NEUT;
        end else begin
            frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
            wd_cnt    <= wd_next;
            state     <= state_next;
            if (target_valid) begin
                target_q <= target;
            end
            // Update uses the pre-edge target register, so a strobe in the
            // tick cycle takes effect one frame later.
            if (frame_tick) begin
                width <= width_next;
            end
        end
    end

endmodule

// File: tb/tb_pwm_slew_limiter.sv
// tb_pwm_slew_limiter: directed scenarios plus random commands, checked
// every cycle against a frame-level behavioural model.

module tb_pwm_slew_limiter;

    localparam int FC   = 20;
    localparam int STEP = 8;
    localparam int NEU  = 127;
    localparam int TO   = 25;

    logic       clk_255kHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] target = 8'd0;
    logic       target_valid = 1'b0;
    logic [7:0] width;
    logic       frame_tick;
    logic       failsafe;
    logic       at_target;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    // model state
    int m_phase = 0;
    int m_tgt   = NEU;
    int m_wd    = 0;
    bit m_fs    = 1'b0;
    int m_w     = NEU;

    pwm_slew_limiter #(
        .FRAME_CYCLES  (FC),
        .STEP_MAX      (STEP),
        .NEUTRAL       (NEU),
        .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk_255kHz  (clk_255kHz),
        .reset       (reset),
        .target      (target),
        .target_valid(target_valid),
        .width       (width),
        .frame_tick  (frame_tick),
        .failsafe    (failsafe),
        .at_target   (at_target)
    );

    always #5 clk_255kHz = ~clk_255kHz;

    // Frame-level reference: width moves toward the goal by at most STEP
    // at the end of every frame; silence for TO frames selects neutral.
    always @(posedge clk_255kHz) begin
        if (reset) begin
            m_phase = 0;
            m_tgt   = NEU;
            m_wd    = 0;
            m_fs    = 1'b0;
            m_w     = NEU;
        end else begin
            int goal;
            int d;
            int mag;
            bit end_of_frame;
            end_of_frame = (m_phase == FC - 1);
            goal = m_fs ? NEU : m_tgt;
            if (end_of_frame) begin
`ifdef PWM_SLEW_BYPASS_EN
                m_w = goal;
`else
                d   = goal - m_w;
                mag = (d < 0) ? -d : d;
                if (mag > STEP) mag = STEP;
                m_w = (d < 0) ? m_w - mag : m_w + mag;
`endif
            end
            if (target_valid) begin
                m_tgt = int'(target);
                m_wd  = 0;
                m_fs  = 1'b0;
            end else begin
                if (end_of_frame && m_wd < TO) m_wd = m_wd + 1;
                if (m_wd == TO) m_fs = 1'b1;
            end
            m_phase = (m_phase + 1) % FC;
        end
    end

    always @(negedge clk_255kHz) begin
        if (chk_en) begin
            bit e_tick;
            bit e_at;
            e_tick = (m_phase == FC - 1);
            e_at   = (m_w == (m_fs ? NEU : m_tgt));
            n_tot++;
            if (int'(width) == m_w && frame_tick == e_tick &&
                failsafe == m_fs && at_target == e_at) begin
                n_pass++;
            end else begin
                $display("FAIL model t=%0t width=%0d/%0d tick=%0b/%0b fs=%0b/%0b at=%0b/%0b (actual/required)",
                         $time, width, m_w, frame_tick, e_tick,
                         failsafe, m_fs, at_target, e_at);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Returns at the negedge where frame_tick is high.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FC + 2; i++) begin
            @(negedge clk_255kHz);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("tick_timeout", 0, 1);
    endtask

    // Wait for a tick and land on the negedge where the new width shows.
    task automatic after_tick();
        wait_tick();
        @(negedge clk_255kHz);
    endtask

    task automatic strobe(input logic [7:0] v);
        target       = v;
        target_valid = 1'b1;
        @(negedge clk_255kHz);
        target_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_255kHz);
        @(negedge clk_255kHz);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        // initial reset
        @(negedge clk_255kHz);
        @(negedge clk_255kHz);
        chk_en = 1'b1;
        chk("rst_width", int'(width), 127);
        chk("rst_failsafe", int'(failsafe), 0);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_tick", int'(frame_tick), 0);
        reset = 1'b0;

        // ramp up
        strobe(8'd255);
        after_tick();
`ifdef PWM_SLEW_BYPASS_EN
        chk("bypass_jump", int'(width), 255);
`else
        chk("ramp_up_t1", int'(width), 135);
        after_tick();
        chk("ramp_up_t2", int'(width), 143);
        for (int k = 3; k <= 15; k++) after_tick();
        chk("ramp_up_t15", int'(width), 247);
        after_tick();
        chk("ramp_up_t16", int'(width), 255);
        chk("ramp_up_at", int'(at_target), 1);
        after_tick();
        chk("ramp_up_hold", int'(width), 255);
`endif

        // ramp down from neutral
        do_reset();
        strobe(8'd0);
        for (int k = 1; k <= 15; k++) after_tick();
`ifndef PWM_SLEW_BYPASS_EN
        chk("ramp_dn_t15", int'(width), 7);
`endif
        after_tick();
        chk("ramp_dn_t16", int'(width), 0);
        after_tick();
        chk("ramp_dn_hold", int'(width), 0);

        // reset mid-ramp toward 200, then first tick timing
        do_reset();
        strobe(8'd200);
        for (int k = 1; k <= 10; k++) after_tick();
        chk("pre_rst_width", int'(width), 200);
        repeat (7) @(negedge clk_255kHz);
        reset = 1'b1;
        @(negedge clk_255kHz);
        chk("midrst_width", int'(width), 127);
        chk("midrst_failsafe", int'(failsafe), 0);
        chk("midrst_at", int'(at_target), 1);
        reset = 1'b0;
        cyc = 1;
        while (!frame_tick && cyc < FC + 5) begin
            @(negedge clk_255kHz);
            cyc++;
        end
        chk("first_tick_cycle", cyc, FC);

        // collision: strobe in the tick cycle
        do_reset();
        wait_tick();
        strobe(8'd200);
        chk("coll_width", int'(width), 127);
        chk("coll_failsafe", int'(failsafe), 0);
        after_tick();
`ifndef PWM_SLEW_BYPASS_EN
        chk("coll_next", int'(width), 135);
`else
        chk("coll_next", int'(width), 200);
`endif

        // watchdog
        do_reset();
        strobe(8'd255);
        for (int k = 1; k <= TO; k++) wait_tick();
        chk("wd_before", int'(failsafe), 0);
        @(negedge clk_255kHz);
        chk("wd_rise", int'(failsafe), 1);
        chk("wd_width", int'(width), 255);
        after_tick();
`ifndef PWM_SLEW_BYPASS_EN
        chk("wd_ramp1", int'(width), 247);
        after_tick();
        chk("wd_ramp2", int'(width), 239);
`else
        chk("wd_ramp1", int'(width), 127);
`endif
        strobe(8'd50);
        chk("wd_clear", int'(failsafe), 0);
        after_tick();
`ifndef PWM_SLEW_BYPASS_EN
        chk("wd_resume", int'(width), 231);
`else
        chk("wd_resume", int'(width), 50);
`endif

        // random commands, quiet stretches and occasional resets
        for (int b = 0; b < 40; b++) begin
            bit quiet;
            quiet = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 600; c++) begin
                @(negedge clk_255kHz);
                reset        = ($urandom_range(0, 2999) == 0);
                target       = 8'($urandom);
                target_valid = !quiet && ($urandom_range(0, 29) == 0);
            end
        end
        @(negedge clk_255kHz);
        reset        = 1'b0;
        target_valid = 1'b0;
        @(negedge clk_255kHz);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
